// File: rtl/alu_sched.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters; grant to rsp_valid is 2 cycles, one op per 3 cycles.
// Backpressure: response held stable while rsp_ready is low and no new grant is issued until it is taken.
module alu_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]     req_op,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_res,
    output logic                     rsp_err,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  rsp_res_q, rsp_res_d;
    logic [2:0]        op_q, op_d;
    logic              rsp_err_q, rsp_err_d;

    logic              gnt_vld;
    logic [ID_W-1:0]   gnt_idx;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_err;

    // First valid index at or after ptr, wrapping around.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!gnt_vld && req_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == IDLE && gnt_vld) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op_q)
            3'd0:    alu_res = a_q + b_q;
            3'd1:    alu_res = a_q - b_q;
            3'd2:    alu_res = a_q & b_q;
            3'd3:    alu_res = a_q | b_q;
            3'd4:    alu_res = a_q ^ b_q;
            3'd5:    alu_res = ~b_q;
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        rsp_res_d = rsp_res_q;
        rsp_err_d = rsp_err_q;
        rsp_id_d  = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    a_d     = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
                    b_d     = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
                    op_d    = req_op[int'(gnt_idx)*3 +: 3];
                    id_d    = gnt_idx;
                    ptr_d   = ID_W'((int'(gnt_idx) + 1) % NUM_REQ);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_res_d = alu_res;
                rsp_err_d = alu_err;
                rsp_id_d  = id_q;
                state_d   = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rsp_res_q <= '0;
            rsp_err_q <= 1'b0;
            rsp_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            rsp_res_q <= rsp_res_d;
            rsp_err_q <= rsp_err_d;
            rsp_id_q  <= rsp_id_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_res   = rsp_res_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: vector table plus fairness, backpressure and mid-op reset sequences.
module tb_alu_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [11:0] req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_res;
    logic        rsp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_sched #(.NUM_REQ(4), .WIDTH(8), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] id;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] res;
        logic       err;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from an IDLE cycle: grant, EXEC, RESP, back to IDLE.
    task automatic run_txn(input logic [3:0] vld, input logic keep, input int exp_id,
                           input logic [7:0] exp_res, input logic exp_err, input string tag);
        req_valid = vld;
        #1;
        chk({tag, " grant"}, 32'(req_ready), 32'(1 << exp_id));
        step();
        if (!keep) req_valid = '0;
        #1;
        chk({tag, " exec_busy"}, 32'(busy), 32'd1);
        chk({tag, " exec_vld"}, 32'(rsp_valid), 32'd0);
        chk({tag, " exec_rdy"}, 32'(req_ready), 32'd0);
        step();
        chk({tag, " rsp_vld"}, 32'(rsp_valid), 32'd1);
        chk({tag, " rsp_res"}, 32'(rsp_res), 32'(exp_res));
        chk({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, " rsp_id"}, 32'(rsp_id), 32'(exp_id));
        step();
        chk({tag, " idle_vld"}, 32'(rsp_valid), 32'd0);
        chk({tag, " idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vt[0] = '{2'd1, 8'd200, 8'd100, 3'd0, 8'd44,  1'b0};
        vt[1] = '{2'd1, 8'd5,   8'd10,  3'd1, 8'd251, 1'b0};
        vt[2] = '{2'd1, 8'h33,  8'h0F,  3'd5, 8'hF0,  1'b0};
        vt[3] = '{2'd0, 8'hCC,  8'hAA,  3'd2, 8'h88,  1'b0};
        vt[4] = '{2'd2, 8'hCC,  8'hAA,  3'd3, 8'hEE,  1'b0};
        vt[5] = '{2'd3, 8'hCC,  8'hAA,  3'd4, 8'h66,  1'b0};
        vt[6] = '{2'd1, 8'd3,   8'd4,   3'd7, 8'd0,   1'b1};
        vt[7] = '{2'd2, 8'd3,   8'd4,   3'd6, 8'd0,   1'b1};
        vt[8] = '{2'd0, 8'd255, 8'd1,   3'd0, 8'd0,   1'b0};

        rst_n     = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;

        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("reset%0d req_ready", c), 32'(req_ready), 32'd0);
            chk($sformatf("reset%0d rsp_valid", c), 32'(rsp_valid), 32'd0);
            chk($sformatf("reset%0d rsp_res", c), 32'(rsp_res), 32'd0);
            chk($sformatf("reset%0d rsp_id", c), 32'(rsp_id), 32'd0);
            chk($sformatf("reset%0d rsp_err", c), 32'(rsp_err), 32'd0);
            chk($sformatf("reset%0d busy", c), 32'(busy), 32'd0);
        end
        req_valid = '0;
        rst_n     = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            req_a  = {4{vt[i].a}};
            req_b  = {4{vt[i].b}};
            req_op = {4{vt[i].op}};
            run_txn(4'(1 << vt[i].id), 1'b0, int'(vt[i].id), vt[i].res, vt[i].err,
                    $sformatf("vec%0d", i));
        end

        // Fairness from a freshly reset pointer.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            req_a[r*8 +: 8]  = 8'(r * 16 + 1);
            req_b[r*8 +: 8]  = 8'd10;
            req_op[r*3 +: 3] = 3'd0;
        end
        for (int t = 0; t < 8; t++) begin
            run_txn(4'hF, 1'b1, t % 4, 8'((t % 4) * 16 + 11), 1'b0, $sformatf("rr%0d", t));
        end
        run_txn(4'b0100, 1'b0, 2, 8'd43, 1'b0, "wrap");

        // Backpressure on requester 3 while requester 0 waits.
        req_a[24 +: 8]  = 8'h0F;
        req_b[24 +: 8]  = 8'hFF;
        req_op[9 +: 3]  = 3'd4;
        rsp_ready = 1'b0;
        req_valid = 4'b1000;
        #1;
        chk("bp grant", 32'(req_ready), 32'd8);
        step();
        req_valid = 4'b0001;
        step();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d rsp_res", k), 32'(rsp_res), 32'hF0);
            chk($sformatf("bp%0d rsp_id", k), 32'(rsp_id), 32'd3);
            chk($sformatf("bp%0d req_ready", k), 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp accept rsp_valid", 32'(rsp_valid), 32'd1);
        step();
        chk("bp idle rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp idle grant", 32'(req_ready), 32'd1);
        run_txn(4'b0001, 1'b0, 0, 8'd11, 1'b0, "bp_next");

        // Reset during EXEC drops the transaction and clears the pointer.
        req_valid = 4'b0100;
        #1;
        chk("mid grant", 32'(req_ready), 32'd4);
        step();
        rst_n     = 1'b0;
        req_valid = 4'b1010;
        #1;
        chk("mid rst req_ready", 32'(req_ready), 32'd0);
        step();
        chk("mid after rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid after busy", 32'(busy), 32'd0);
        chk("mid after req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mid post grant", 32'(req_ready), 32'd2);
        step();
        req_valid = '0;
        chk("mid post exec rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        chk("mid post rsp_id", 32'(rsp_id), 32'd1);
        chk("mid post rsp_res", 32'(rsp_res), 32'd27);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
